// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle controller.
//   - ALU function codes driven on alu_funct
//   - MIPS opcode / funct constants for the supported subset
//   - 4-bit state enum (also exported on the debug state port)
//   - ALU operand and PC source select constants
package mc_ctrl_pkg;

  // ALU function codes
  localparam logic [5:0] ALU_ADDU = 6'b001001;
  localparam logic [5:0] ALU_SUBU = 6'b001010;
  localparam logic [5:0] ALU_SLL  = 6'b100001;
  localparam logic [5:0] ALU_SLLV = 6'b110101;
  localparam logic [5:0] ALU_SLTI = 6'b101010;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SLLV = 6'b000100;

  // ALU operand A selects
  localparam logic [1:0] SRC_A_PC = 2'b00;
  localparam logic [1:0] SRC_A_A  = 2'b01;
  localparam logic [1:0] SRC_A_B  = 2'b10;

  // ALU operand B selects
  localparam logic [2:0] SRC_B_B       = 3'b000;
  localparam logic [2:0] SRC_B_FOUR    = 3'b001;
  localparam logic [2:0] SRC_B_IMM     = 3'b010;
  localparam logic [2:0] SRC_B_IMM_SH2 = 3'b011;
  localparam logic [2:0] SRC_B_A       = 3'b100;

  // PC source selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11,
    ST_HALT     = 4'd12
  } state_e;

  // True for the R-type funct codes the datapath can execute.
  function automatic logic is_supported_funct(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_ADDU, FN_SUBU, FN_SLL, FN_SLLV: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: combinational ALU control for the multi-cycle controller.
// Ports:
//   state_i     - current controller state
//   funct_i     - instr[5:0], selects the R-type operation in R_EXEC
//   alu_funct_o - 6-bit ALU function code (ADDU when the state does not care)
//   alu_src_a_o - operand A select
//   alu_src_b_o - operand B select
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] funct_i,
  output logic [5:0] alu_funct_o,
  output logic [1:0] alu_src_a_o,
  output logic [2:0] alu_src_b_o
);

  // ALU code and operand selects per state
  always_comb begin
    alu_funct_o = ALU_ADDU;
    alu_src_a_o = SRC_A_PC;
    alu_src_b_o = SRC_B_B;
    case (state_i)
      ST_FETCH: begin
        alu_src_b_o = SRC_B_FOUR;
      end
      ST_DECODE: begin
        // Branch target precomputed into ALUOut
        alu_src_b_o = SRC_B_IMM_SH2;
      end
      ST_MEM_ADDR: begin
        alu_src_a_o = SRC_A_A;
        alu_src_b_o = SRC_B_IMM;
      end
      ST_I_EXEC: begin
        alu_funct_o = ALU_SLTI;
        alu_src_a_o = SRC_A_A;
        alu_src_b_o = SRC_B_IMM;
      end
      ST_BRANCH: begin
        alu_funct_o = ALU_SUBU;
        alu_src_a_o = SRC_A_A;
      end
      ST_R_EXEC: begin
        case (funct_i)
          FN_ADDU: begin
            alu_src_a_o = SRC_A_A;
          end
          FN_SUBU: begin
            alu_funct_o = ALU_SUBU;
            alu_src_a_o = SRC_A_A;
          end
          FN_SLL: begin
            // Shift amount comes from the shamt field inside the ALU
            alu_funct_o = ALU_SLL;
            alu_src_a_o = SRC_A_B;
          end
          FN_SLLV: begin
            alu_funct_o = ALU_SLLV;
            alu_src_a_o = SRC_A_B;
            alu_src_b_o = SRC_B_A;
          end
          default: begin
            alu_funct_o = ALU_ADDU;
          end
        endcase
      end
      default: begin
        alu_funct_o = ALU_ADDU;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle controller for the MIPS subset
// addu, subu, sll, sllv, slti, lw, sw, beq, j.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   instr              - instruction register contents (not latched here)
//   mem_ready          - memory handshake for FETCH / MEM_RD / MEM_WR
//   alu_funct, alu_src_a, alu_src_b, pc_source - datapath controls
//   pc_write ... reg_write - datapath strobes and selects
//   instr_done         - pulse in the last cycle of each instruction
//   halted             - high in HALT (sticky until reset)
//   state              - current state for debug
// All outputs are forced to 0 while rst_n is low, without waiting for a clock.
module mc_control
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic [5:0]  alu_funct,
  output logic [1:0]  alu_src_a,
  output logic [2:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        instr_done,
  output logic        halted,
  output logic [3:0]  state
);

  state_e     state_q, state_d;
  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       unused_instr_s;

  logic [5:0] alu_funct_s;
  logic [1:0] alu_src_a_s;
  logic [2:0] alu_src_b_s;
  logic [1:0] pc_source_s;
  logic       pc_write_s, pc_write_cond_s, i_or_d_s, mem_read_s, mem_write_s;
  logic       ir_write_s, reg_dst_s, mem_to_reg_s, reg_write_s;
  logic       instr_done_s, halted_s;

  assign opcode_s       = instr[31:26];
  assign funct_s        = instr[5:0];
  assign unused_instr_s = ^instr[25:6];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opcode_s)
          OP_RTYPE: begin
            if (is_supported_funct(funct_s)) begin
              state_d = ST_R_EXEC;
            end else begin
              state_d = ST_HALT;
            end
          end
          OP_SLTI:      state_d = ST_I_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_HALT;
        endcase
      end
      ST_MEM_ADDR: begin
        // Only lw and sw reach here, so anything not lw is sw
        if (opcode_s == OP_LW) begin
          state_d = ST_MEM_RD;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_MEM_RD: begin
        if (mem_ready) begin
          state_d = ST_MEM_WB;
        end else begin
          state_d = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_R_EXEC: state_d = ST_R_WB;
      ST_I_EXEC: state_d = ST_I_WB;
      ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_HALT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  mc_alu_decode u_alu_decode (
    .state_i     (state_q),
    .funct_i     (funct_s),
    .alu_funct_o (alu_funct_s),
    .alu_src_a_o (alu_src_a_s),
    .alu_src_b_o (alu_src_b_s)
  );

  // Strobe decode; mem_ready gates only the FETCH IR/PC update and the sw completion
  always_comb begin
    pc_source_s     = PC_SRC_ALU;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_write_s     = 1'b0;
    instr_done_s    = 1'b0;
    halted_s        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_s = 1'b1;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
        end else begin
          ir_write_s = 1'b0;
          pc_write_s = 1'b0;
        end
      end
      ST_MEM_RD: begin
        i_or_d_s   = 1'b1;
        mem_read_s = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_MEM_WR: begin
        i_or_d_s     = 1'b1;
        mem_write_s  = 1'b1;
        instr_done_s = mem_ready;
      end
      ST_R_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_I_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_BRANCH: begin
        pc_write_cond_s = 1'b1;
        pc_source_s     = PC_SRC_ALUOUT;
        instr_done_s    = 1'b1;
      end
      ST_JUMP: begin
        pc_write_s   = 1'b1;
        pc_source_s  = PC_SRC_JUMP;
        instr_done_s = 1'b1;
      end
      ST_HALT: begin
        halted_s = 1'b1;
      end
      default: begin
        halted_s = 1'b0;
      end
    endcase
  end

  // Reset clears every output immediately, even though state alone would decode as FETCH
  assign alu_funct     = {6{rst_n}} & alu_funct_s;
  assign alu_src_a     = {2{rst_n}} & alu_src_a_s;
  assign alu_src_b     = {3{rst_n}} & alu_src_b_s;
  assign pc_source     = {2{rst_n}} & pc_source_s;
  assign pc_write      = rst_n & pc_write_s;
  assign pc_write_cond = rst_n & pc_write_cond_s;
  assign i_or_d        = rst_n & i_or_d_s;
  assign mem_read      = rst_n & mem_read_s;
  assign mem_write     = rst_n & mem_write_s;
  assign ir_write      = rst_n & ir_write_s;
  assign reg_dst       = rst_n & reg_dst_s;
  assign mem_to_reg    = rst_n & mem_to_reg_s;
  assign reg_write     = rst_n & reg_write_s;
  assign instr_done    = rst_n & instr_done_s;
  assign halted        = rst_n & halted_s;
  assign state         = state_q;

endmodule
